memory_stage: RTL and testbench

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/memory_stage.sv | 234 +++++++++++++++++++++++
 tb/tb_memory_stage.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// Memory stage of the dual-issue core: performs data-memory accesses for the two EX/MEM slots and builds MEM/WB.
// Latency: 1 cycle for ALU-only pairs; memory pairs take one cycle to start, each access runs until it is acked or times out, plus a retire cycle.
// Backpressure: stall is raised combinationally while any access is pending; upstream must hold ex_mem_0/1 until stall drops.
//
// Ports:
//   clk, rst                 clock and asynchronous active-low reset
//   ex_mem_0/1               EX/MEM slot contents from execute
//   mem_wb_0/1               registered MEM/WB slot contents
//   mem_fwd_data_0/1         ALU result forwarding taps for execute
//   stall                    hold request to upstream
//   dmem_*                   single-outstanding data-memory bus
//   bus_error, halted        sticky status flags

package neocore_pkg;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [4:0]  rd_addr;
      logic [4:0]  rd2_addr;
      logic        rd_we;
      logic        rd2_we;
      logic [31:0] alu_result;
      logic        mem_read;
      logic        mem_write;
      logic [31:0] mem_addr;
      logic [15:0] mem_wdata;
      logic [1:0]  mem_size;
      logic        is_halt;
   } ex_mem_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [4:0]  rd_addr;
      logic [4:0]  rd2_addr;
      logic        rd_we;
      logic        rd2_we;
      logic [31:0] wb_data;
      logic        is_halt;
   } mem_wb_t;

endpackage

module memory_stage
   import neocore_pkg::*;
#(
   parameter int MAX_WAIT = 255
)
(
   input  logic        clk,
   input  logic        rst,
   input  ex_mem_t     ex_mem_0,
   input  ex_mem_t     ex_mem_1,
   output mem_wb_t     mem_wb_0,
   output mem_wb_t     mem_wb_1,
   output logic [15:0] mem_fwd_data_0,
   output logic [15:0] mem_fwd_data_1,
   output logic        stall,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [1:0]  dmem_size,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        bus_error,
   output logic        halted
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC0 = 2'd1,
      ACC1 = 2'd2,
      DONE = 2'd3
   } state_t;

   // The counter only has to hold 0..MAX_WAIT-1: the last value ends the access.
   localparam int             CW        = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
   localparam logic [CW-1:0]  WAIT_LAST = CW'(MAX_WAIT - 1);

   state_t          state;
   state_t          state_nxt;
   logic [CW-1:0]   wait_cnt;
   logic [31:0]     ld_data_0;
   logic [31:0]     ld_data_1;

   logic            mem_op_0;
   logic            mem_op_1;
   logic            acc_state;
   logic            timeout;
   logic            acc_end;
   logic [1:0]      cur_size;
   logic [31:0]     ld_sel;

   function automatic logic is_load(input ex_mem_t s);
      // A slot with both read and write set is a store.
      return s.valid && s.mem_read && !s.mem_write;
   endfunction

   function automatic logic [31:0] load_pick(input logic [1:0] size, input logic [31:0] d);
      logic [31:0] r;
      r = d;
      case (size)
         2'b00:   r = {24'h0, d[7:0]};
         2'b01:   r = {16'h0, d[15:0]};
         default: r = d;
      endcase
      return r;
   endfunction

   function automatic mem_wb_t wb_of(input ex_mem_t s, input logic [31:0] ld);
      mem_wb_t w;
      w.valid    = s.valid;
      w.pc       = s.pc;
      w.rd_addr  = s.rd_addr;
      w.rd2_addr = s.rd2_addr;
      w.rd_we    = s.rd_we;
      w.rd2_we   = s.rd2_we;
      w.wb_data  = is_load(s) ? ld : s.alu_result;
      w.is_halt  = s.is_halt;
      return w;
   endfunction

   assign mem_op_0  = ex_mem_0.valid && (ex_mem_0.mem_read || ex_mem_0.mem_write);
   assign mem_op_1  = ex_mem_1.valid && (ex_mem_1.mem_read || ex_mem_1.mem_write);
   assign acc_state = (state == ACC0) || (state == ACC1);
   assign timeout   = (wait_cnt == WAIT_LAST);
   // Ack wins over timeout: an ack in the last wait cycle still returns real data.
   assign acc_end   = dmem_ack || timeout;
   assign cur_size  = (state == ACC1) ? ex_mem_1.mem_size : ex_mem_0.mem_size;
   assign ld_sel    = dmem_ack ? load_pick(cur_size, dmem_rdata) : 32'h0;

   assign mem_fwd_data_0 = ex_mem_0.alu_result[15:0];
   assign mem_fwd_data_1 = ex_mem_1.alu_result[15:0];

   always_comb begin
      state_nxt  = state;
      stall      = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      dmem_addr  = 32'h0;
      dmem_wdata = 32'h0;
      dmem_size  = 2'b00;
      case (state)
         IDLE: begin
            if (mem_op_0 || mem_op_1) begin
               stall     = 1'b1;
               state_nxt = mem_op_0 ? ACC0 : ACC1;
            end
         end
         ACC0: begin
            stall      = 1'b1;
            dmem_req   = 1'b1;
            dmem_we    = ex_mem_0.mem_write;
            dmem_addr  = ex_mem_0.mem_addr;
            dmem_wdata = {16'h0, ex_mem_0.mem_wdata};
            dmem_size  = ex_mem_0.mem_size;
            if (acc_end) begin
               state_nxt = mem_op_1 ? ACC1 : DONE;
            end
         end
         ACC1: begin
            stall      = 1'b1;
            dmem_req   = 1'b1;
            dmem_we    = ex_mem_1.mem_write;
            dmem_addr  = ex_mem_1.mem_addr;
            dmem_wdata = {16'h0, ex_mem_1.mem_wdata};
            dmem_size  = ex_mem_1.mem_size;
            if (acc_end) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
      // State is forced to IDLE in reset, but a memory op on the inputs
      // would still raise stall there; mask it so reset is truly quiet.
      if (!rst) begin
         stall = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         wait_cnt  <= '0;
         ld_data_0 <= 32'h0;
         ld_data_1 <= 32'h0;
         mem_wb_0  <= '0;
         mem_wb_1  <= '0;
         bus_error <= 1'b0;
         halted    <= 1'b0;
      end else begin
         state <= state_nxt;

         // Cleared on every state change so each access gets a fresh budget.
         if (acc_state && (state_nxt == state)) begin
            wait_cnt <= wait_cnt + CW'(1);
         end else begin
            wait_cnt <= '0;
         end

         if ((state == ACC0) && acc_end) begin
            ld_data_0 <= ld_sel;
         end
         if ((state == ACC1) && acc_end) begin
            ld_data_1 <= ld_sel;
         end
         if (acc_state && timeout && !dmem_ack) begin
            bus_error <= 1'b1;
         end

         if (!stall) begin
            // IDLE without memory ops, or DONE: retire both slots.
            mem_wb_0 <= wb_of(ex_mem_0, ld_data_0);
            mem_wb_1 <= wb_of(ex_mem_1, ld_data_1);
            if ((ex_mem_0.valid && ex_mem_0.is_halt) ||
                (ex_mem_1.valid && ex_mem_1.is_halt)) begin
               halted <= 1'b1;
            end
         end else begin
            // Bubble while the pair is still in flight.
            mem_wb_0.valid <= 1'b0;
            mem_wb_1.valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed scenarios followed by randomized traffic, checked against a transaction-level model.
// Latency: outputs compared every cycle (combinational at negedge, registered just after posedge).
// Backpressure: the random driver behaves as upstream and holds the slots while stall is seen high.

module tb_memory_stage;
   import neocore_pkg::*;

   localparam int MAXW = 4;

   logic        clk;
   logic        rst_n;
   ex_mem_t     ex_mem_0;
   ex_mem_t     ex_mem_1;
   mem_wb_t     mem_wb_0;
   mem_wb_t     mem_wb_1;
   logic [15:0] mem_fwd_data_0;
   logic [15:0] mem_fwd_data_1;
   logic        stall;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [1:0]  dmem_size;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;
   logic        bus_error;
   logic        halted;

   int n_vec = 0;
   int n_err = 0;
   logic stall_seen = 1'b0;

   memory_stage #(.MAX_WAIT(MAXW)) dut (
      .clk            (clk),
      .rst            (rst_n),
      .ex_mem_0       (ex_mem_0),
      .ex_mem_1       (ex_mem_1),
      .mem_wb_0       (mem_wb_0),
      .mem_wb_1       (mem_wb_1),
      .mem_fwd_data_0 (mem_fwd_data_0),
      .mem_fwd_data_1 (mem_fwd_data_1),
      .stall          (stall),
      .dmem_req       (dmem_req),
      .dmem_we        (dmem_we),
      .dmem_addr      (dmem_addr),
      .dmem_wdata     (dmem_wdata),
      .dmem_size      (dmem_size),
      .dmem_ack       (dmem_ack),
      .dmem_rdata     (dmem_rdata),
      .bus_error      (bus_error),
      .halted         (halted)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic bit is_mem(input ex_mem_t s);
      return s.valid && (s.mem_read || s.mem_write);
   endfunction

   function automatic logic [31:0] pick(input logic [1:0] sz, input logic [31:0] d);
      if (sz == 2'b00) return d & 32'h0000_00FF;
      if (sz == 2'b01) return d & 32'h0000_FFFF;
      return d;
   endfunction

   function automatic mem_wb_t retire_of(input ex_mem_t s, input logic [31:0] ld);
      mem_wb_t w;
      w = '0;
      w.valid    = s.valid;
      w.pc       = s.pc;
      w.rd_addr  = s.rd_addr;
      w.rd2_addr = s.rd2_addr;
      w.rd_we    = s.rd_we;
      w.rd2_we   = s.rd2_we;
      w.is_halt  = s.is_halt;
      w.wb_data  = (is_mem(s) && !s.mem_write) ? ld : s.alu_result;
      return w;
   endfunction

   int          m_q[$];      // slot indices whose access is still outstanding
   int          m_wait;      // cycles spent on the current access
   bit          m_retire;    // pair retires at the coming edge
   logic [31:0] m_ld[2];
   mem_wb_t     m_wb[2];
   bit          m_berr;
   bit          m_halt;

   initial begin
      ex_mem_t     s[2];
      ex_mem_t     c;
      logic        exp_stall;
      logic        exp_req;
      int          k;
      m_q.delete(); m_wait = 0; m_retire = 0; m_ld[0] = '0; m_ld[1] = '0;
      m_wb[0] = '0; m_wb[1] = '0; m_berr = 0; m_halt = 0;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            chk("fwd0", 128'(mem_fwd_data_0), 128'(ex_mem_0.alu_result[15:0]));
            chk("fwd1", 128'(mem_fwd_data_1), 128'(ex_mem_1.alu_result[15:0]));
            if (m_retire) begin
               exp_stall = 1'b0; exp_req = 1'b0;
            end else if (m_q.size() != 0) begin
               exp_stall = 1'b1; exp_req = 1'b1;
            end else begin
               exp_stall = is_mem(ex_mem_0) || is_mem(ex_mem_1);
               exp_req   = 1'b0;
            end
            chk("stall", 128'(stall), 128'(exp_stall));
            chk("dmem_req", 128'(dmem_req), 128'(exp_req));
            if (exp_req) begin
               c = (m_q[0] == 0) ? ex_mem_0 : ex_mem_1;
               chk("dmem_we", 128'(dmem_we), 128'(c.mem_write));
               chk("dmem_addr", 128'(dmem_addr), 128'(c.mem_addr));
               chk("dmem_wdata", 128'(dmem_wdata), 128'({16'h0, c.mem_wdata}));
               chk("dmem_size", 128'(dmem_size), 128'(c.mem_size));
            end
         end
         @(posedge clk);
         if (!rst_n) begin
            m_q.delete(); m_wait = 0; m_retire = 0; m_ld[0] = '0; m_ld[1] = '0;
            m_wb[0] = '0; m_wb[1] = '0; m_berr = 0; m_halt = 0;
         end else begin
            s[0] = ex_mem_0; s[1] = ex_mem_1;
            m_wb[0].valid = 1'b0; m_wb[1].valid = 1'b0;
            if (m_retire) begin
               m_wb[0] = retire_of(s[0], m_ld[0]);
               m_wb[1] = retire_of(s[1], m_ld[1]);
               m_retire = 0;
            end else if (m_q.size() != 0) begin
               m_wait++;
               if (dmem_ack || m_wait == MAXW) begin
                  k = m_q.pop_front();
                  m_ld[k] = dmem_ack ? pick(s[k].mem_size, dmem_rdata) : 32'h0;
                  if (!dmem_ack) m_berr = 1;
                  m_wait = 0;
                  if (m_q.size() == 0) m_retire = 1;
               end
            end else if (is_mem(s[0]) || is_mem(s[1])) begin
               for (int i = 0; i < 2; i++) if (is_mem(s[i])) m_q.push_back(i);
               m_wait = 0;
            end else begin
               m_wb[0] = retire_of(s[0], 32'h0);
               m_wb[1] = retire_of(s[1], 32'h0);
            end
            for (int i = 0; i < 2; i++) if (m_wb[i].valid && m_wb[i].is_halt) m_halt = 1;
         end
         #1;
         if (rst_n) begin
            chk("wb0_valid", 128'(mem_wb_0.valid), 128'(m_wb[0].valid));
            chk("wb1_valid", 128'(mem_wb_1.valid), 128'(m_wb[1].valid));
            if (m_wb[0].valid) chk("wb0", 128'(mem_wb_0), 128'(m_wb[0]));
            if (m_wb[1].valid) chk("wb1", 128'(mem_wb_1), 128'(m_wb[1]));
            chk("bus_error", 128'(bus_error), 128'(m_berr));
            chk("halted", 128'(halted), 128'(m_halt));
         end
      end
   end

   // ---------------- stimulus ----------------
   always @(negedge clk) stall_seen = stall;

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle(input int n);
      ex_mem_0 = '0; ex_mem_1 = '0; dmem_ack = 1'b0;
      repeat (n) tick();
   endtask

   function automatic ex_mem_t mk(input logic rd, input logic wr, input logic [1:0] sz,
                                  input logic [31:0] addr, input logic [15:0] wd,
                                  input logic [31:0] alu, input logic halt);
      ex_mem_t s;
      s = '0;
      s.valid      = 1'b1;
      s.pc         = 32'h0000_1000;
      s.rd_addr    = 5'd1;
      s.rd2_addr   = 5'd2;
      s.rd_we      = 1'b1;
      s.alu_result = alu;
      s.mem_read   = rd;
      s.mem_write  = wr;
      s.mem_addr   = addr;
      s.mem_wdata  = wd;
      s.mem_size   = sz;
      s.is_halt    = halt;
      return s;
   endfunction

   function automatic ex_mem_t rnd_slot();
      ex_mem_t s;
      s = '0;
      s.valid      = ($urandom_range(0, 9) != 0);
      s.pc         = 32'($urandom);
      s.rd_addr    = 5'($urandom);
      s.rd2_addr   = 5'($urandom);
      s.rd_we      = 1'($urandom);
      s.rd2_we     = 1'($urandom);
      s.alu_result = 32'($urandom);
      s.mem_read   = ($urandom_range(0, 2) == 0);
      s.mem_write  = ($urandom_range(0, 3) == 0);
      s.mem_addr   = 32'($urandom);
      s.mem_wdata  = 16'($urandom);
      s.mem_size   = 2'($urandom);
      s.is_halt    = ($urandom_range(0, 29) == 0);
      return s;
   endfunction

   initial begin
      logic prev;
      int   rises;
      logic ack_pat[6];

      rst_n = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
      ex_mem_0 = mk(1'b1, 1'b0, 2'b10, 32'h40, 16'h0, 32'h0, 1'b0);
      ex_mem_1 = '0;
      #23;
      chk("rst_stall", 128'(stall), 128'(1'b0));
      chk("rst_req", 128'(dmem_req), 128'(1'b0));
      chk("rst_wb0_valid", 128'(mem_wb_0.valid), 128'(1'b0));
      chk("rst_bus_error", 128'(bus_error), 128'(1'b0));
      chk("rst_halted", 128'(halted), 128'(1'b0));
      ex_mem_0 = '0;
      @(posedge clk); #2 rst_n = 1'b1;
      idle(2);

      // ALU-only pair retires one cycle later
      ex_mem_0 = mk(1'b0, 1'b0, 2'b00, 32'h0, 16'h0, 32'h0000_1234, 1'b0);
      #4 chk("alu_stall", 128'(stall), 128'(1'b0));
      tick();
      chk("alu_wb_valid", 128'(mem_wb_0.valid), 128'(1'b1));
      chk("alu_wb_data", 128'(mem_wb_0.wb_data), 128'(32'h0000_1234));
      idle(2);

      // Byte load acked on the second access cycle
      ex_mem_0 = mk(1'b1, 1'b0, 2'b00, 32'h100, 16'h0, 32'hDEAD_0000, 1'b0);
      dmem_rdata = 32'hAABB_CCDD;
      ack_pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      prev = 1'b0; rises = 0;
      for (int c = 0; c < 4; c++) begin
         dmem_ack = ack_pat[c];
         #4;
         if (dmem_req && !prev) rises++;
         prev = dmem_req;
         if (c == 1) chk("lb_addr", 128'(dmem_addr), 128'(32'h100));
         tick();
      end
      chk("lb_one_req", 128'(rises), 128'(1));
      chk("lb_wb_valid", 128'(mem_wb_0.valid), 128'(1'b1));
      chk("lb_wb_data", 128'(mem_wb_0.wb_data), 128'(32'h0000_00DD));
      idle(2);

      // Store in slot 0 then half load in slot 1
      ex_mem_0 = mk(1'b0, 1'b1, 2'b01, 32'h200, 16'h5A5A, 32'h0000_0200, 1'b0);
      ex_mem_1 = mk(1'b1, 1'b0, 2'b01, 32'h300, 16'h0, 32'h0000_0300, 1'b0);
      dmem_rdata = 32'h0000_BEEF;
      ack_pat = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      for (int c = 0; c < 4; c++) begin
         dmem_ack = ack_pat[c];
         #4;
         if (c == 1) begin
            chk("st_we", 128'(dmem_we), 128'(1'b1));
            chk("st_addr", 128'(dmem_addr), 128'(32'h200));
            chk("st_wdata", 128'(dmem_wdata), 128'(32'h0000_5A5A));
         end
         if (c == 2) begin
            chk("lh_we", 128'(dmem_we), 128'(1'b0));
            chk("lh_addr", 128'(dmem_addr), 128'(32'h300));
         end
         tick();
      end
      chk("st_wb0_data", 128'(mem_wb_0.wb_data), 128'(32'h0000_0200));
      chk("lh_wb1_data", 128'(mem_wb_1.wb_data), 128'(32'h0000_BEEF));
      idle(2);

      // Halt in slot 1 behind a slot 0 load: flag rises only when the pair retires
      ex_mem_0 = mk(1'b1, 1'b0, 2'b00, 32'h40, 16'h0, 32'h0, 1'b0);
      ex_mem_1 = mk(1'b0, 1'b0, 2'b00, 32'h0, 16'h0, 32'h0, 1'b1);
      ack_pat = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      for (int c = 0; c < 3; c++) begin
         dmem_ack = ack_pat[c];
         #4 chk("halt_early", 128'(halted), 128'(1'b0));
         tick();
      end
      chk("halt_done", 128'(halted), 128'(1'b1));
      idle(2);

      // Load that is never acked times out after MAXW access cycles
      ex_mem_0 = mk(1'b1, 1'b0, 2'b10, 32'h80, 16'h0, 32'h0, 1'b0);
      dmem_rdata = 32'h1234_5678;
      dmem_ack = 1'b0;
      for (int c = 0; c < 6; c++) begin
         #4;
         if (c == 4) begin
            chk("to_berr_pre", 128'(bus_error), 128'(1'b0));
            chk("to_req_last", 128'(dmem_req), 128'(1'b1));
         end
         if (c == 5) begin
            chk("to_berr_set", 128'(bus_error), 128'(1'b1));
            chk("to_req_done", 128'(dmem_req), 128'(1'b0));
         end
         tick();
      end
      chk("to_wb_data", 128'(mem_wb_0.wb_data), 128'(32'h0));
      ex_mem_0 = '0;
      #4;
      chk("to_idle_stall", 128'(stall), 128'(1'b0));
      chk("to_idle_req", 128'(dmem_req), 128'(1'b0));
      idle(2);

      // Reset asserted while slot 1 access is in progress
      ex_mem_0 = mk(1'b0, 1'b1, 2'b10, 32'h10, 16'h1111, 32'h0, 1'b0);
      ex_mem_1 = mk(1'b1, 1'b0, 2'b10, 32'h20, 16'h0, 32'h0, 1'b0);
      ack_pat = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      for (int c = 0; c < 2; c++) begin
         dmem_ack = ack_pat[c];
         tick();
      end
      dmem_ack = 1'b0;
      #4 chk("rmid_acc1_addr", 128'(dmem_addr), 128'(32'h20));
      #1 rst_n = 1'b0;
      #1;
      chk("rmid_req", 128'(dmem_req), 128'(1'b0));
      chk("rmid_stall", 128'(stall), 128'(1'b0));
      chk("rmid_wb0_valid", 128'(mem_wb_0.valid), 128'(1'b0));
      chk("rmid_wb1_valid", 128'(mem_wb_1.valid), 128'(1'b0));
      ex_mem_0 = '0; ex_mem_1 = '0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #4 chk("rmid_no_req", 128'(dmem_req), 128'(1'b0));
         tick();
      end

      // Randomized traffic with upstream flow control
      for (int n = 0; n < 800; n++) begin
         if (!stall_seen) begin
            ex_mem_0 = rnd_slot();
            ex_mem_1 = rnd_slot();
         end
         dmem_ack   = ($urandom_range(0, 99) < 35);
         dmem_rdata = 32'($urandom);
         tick();
      end
      idle(8);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
